// File: rtl/spi_pkg.sv
// Shared types for the SPI slave: FSM state encoding and default word width.
// Pure definitions; no logic, no latency.
package spi_pkg;
  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;
endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the tx holding-register handshake and rx word outputs.
// slave modport is the block's view; master modport is the driving side.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic         sclk_i;
  logic         cs_n_i;
  logic         mosi_i;
  logic         miso_o;
  logic         miso_oe_o;
  logic [N-1:0] tx_data_i;
  logic         tx_valid_i;
  logic         tx_ready_o;
  logic [N-1:0] rx_data_o;
  logic         rx_valid_o;
  logic         tx_underrun_o;
  logic         frame_abort_o;

  modport slave (
    input  sclk_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i,
    output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           tx_underrun_o, frame_abort_o
  );

  modport master (
    output sclk_i, cs_n_i, mosi_i, tx_data_i, tx_valid_i,
    input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           tx_underrun_o, frame_abort_o
  );
endinterface

// File: rtl/spi_slave_bit_counter.sv
// Bit position within the current word: counts 0..N-1 on enable, wraps on the last bit.
// Clear has priority over enable; registered output, flag is combinational from count.
module spi_slave_bit_counter
  import spi_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                 clk_c,
  input  logic                 reset_r,
  input  logic                 clear,
  input  logic                 en,
  output logic [$clog2(N)-1:0] count,
  output logic                 last
);
  localparam int             CW       = $clog2(N);
  localparam logic [CW-1:0]  LAST_VAL = CW'(N - 1);

  assign last = (count == LAST_VAL);

  always_ff @(posedge clk_c) begin
    if (reset_r || clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + CW'(1);
    end
  end
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave with one-entry tx holding register; SPI inputs see 3 clk_c cycles of sync/edge latency.
// tx_ready drops while the holding register is full or being reloaded; rx has no backpressure.
module spi_slave
  import spi_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic       clk_c,
  input logic       reset_r,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(N);

  logic [1:0]    sclk_sync, cs_sync, mosi_sync;
  logic          sclk_d, cs_d;
  logic          sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

  state_t        state_q, state_d;
  logic          reload, shift_rise, shift_fall, abort;

  logic [N-1:0]  hold_q;
  logic          hold_full_q;
  logic          tx_ready;
  logic [N-1:0]  tx_sr;
  logic [N-2:0]  rx_sr;
  logic [N-1:0]  rx_next;
  logic [N-1:0]  rx_data_q;
  logic          rx_valid_q, underrun_q, abort_q;

  logic [CW-1:0] count;
  logic          last;

  // Synchronizers reset to the idle bus levels so reset itself never looks like an edge.
  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.sclk_i};
      cs_sync   <= {cs_sync[0], bus.cs_n_i};
      mosi_sync <= {mosi_sync[0], bus.mosi_i};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign mosi_bit  = mosi_sync[1];

  always_ff @(posedge clk_c) begin
    if (reset_r) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Deselect wins over any sclk activity seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    reload     = 1'b0;
    shift_rise = 1'b0;
    shift_fall = 1'b0;
    abort      = 1'b0;
    if (cs_rise) begin
      state_d = IDLE;
      abort   = (state_q == SHIFT) && (count != '0);
    end else begin
      case (state_q)
        IDLE:  if (cs_fall) state_d = LOAD;
        LOAD: begin
          state_d = SHIFT;
          reload  = 1'b1;
        end
        SHIFT: begin
          shift_rise = sclk_rise;
          // A fall with the counter back at 0 follows the last bit of a word.
          if (sclk_fall) begin
            if (count == '0) reload     = 1'b1;
            else             shift_fall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  spi_slave_bit_counter #(.N(N)) u_bit_counter (
    .clk_c   (clk_c),
    .reset_r (reset_r),
    .clear   (cs_rise),
    .en      (shift_rise),
    .count   (count),
    .last    (last)
  );

  assign tx_ready = ~hold_full_q & ~reload;

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (reload && hold_full_q) begin
      hold_full_q <= 1'b0;
    end else if (bus.tx_valid_i && tx_ready) begin
      hold_q      <= bus.tx_data_i;
      hold_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_c) begin
    if (reset_r || cs_rise) begin
      tx_sr <= '0;
    end else if (reload) begin
      tx_sr <= hold_full_q ? hold_q : '0;
    end else if (shift_fall) begin
      tx_sr <= {tx_sr[N-2:0], 1'b0};
    end
  end

  assign rx_next = {rx_sr, mosi_bit};

  always_ff @(posedge clk_c) begin
    if (reset_r || cs_rise) rx_sr <= '0;
    else if (shift_rise)    rx_sr <= rx_next[N-2:0];
  end

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (shift_rise && last) rx_data_q <= rx_next;
      rx_valid_q <= shift_rise & last;
      underrun_q <= reload & ~hold_full_q;
      abort_q    <= abort;
    end
  end

  assign bus.miso_oe_o     = (state_q != IDLE);
  assign bus.miso_o        = (state_q != IDLE) & tx_sr[N-1];
  assign bus.tx_ready_o    = tx_ready;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.tx_underrun_o = underrun_q;
  assign bus.frame_abort_o = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master at clk_c/8 plus pulse monitors on the rx/status outputs.
module tb_spi_slave;
  localparam int N = 8;

  logic clk_c   = 1'b0;
  logic reset_r = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  int           rx_cnt  = 0;
  int           und_cnt = 0;
  int           abt_cnt = 0;
  int           acc_cnt = 0;
  logic [N-1:0] rx_log [0:31];

  spi_slave_if #(.N(N)) bus ();

  spi_slave #(.N(N)) dut (
    .clk_c   (clk_c),
    .reset_r (reset_r),
    .bus     (bus.slave)
  );

  always #5 clk_c = ~clk_c;

  always @(negedge clk_c) begin
    if (bus.rx_valid_o) begin
      rx_log[rx_cnt[4:0]] = bus.rx_data_o;
      rx_cnt = rx_cnt + 1;
    end
    if (bus.tx_underrun_o) und_cnt = und_cnt + 1;
    if (bus.frame_abort_o) abt_cnt = abt_cnt + 1;
    if (bus.tx_valid_i && bus.tx_ready_o) acc_cnt = acc_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_c);
    #1;
  endtask

  task automatic write_tx(input logic [N-1:0] d);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (bus.tx_ready_o) break;
      tick(1);
    end
    checks++;
    if (bus.tx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL write_tx_timeout: tx_ready=%b want 1", bus.tx_ready_o);
    end
    tick(1);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic frame_start();
    bus.cs_n_i = 1'b0;
    tick(4);
  endtask

  // Shifts nb bits MSB first; with end_frame the last sclk fall coincides with cs_n release.
  task automatic spi_bits(input logic [N-1:0] mo, input int nb, input bit end_frame,
                          output logic [N-1:0] mi);
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      bus.mosi_i = mo[N-1-i];
      tick(4);
      mi[N-1-i]  = bus.miso_o;
      bus.sclk_i = 1'b1;
      tick(4);
      bus.sclk_i = 1'b0;
      if (end_frame && i == nb - 1) bus.cs_n_i = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.tx_ready_o !== 1'b1) begin errors++; $display("FAIL %s_tx_ready: got %b want 1", tag, bus.tx_ready_o); end
    checks++;
    if (bus.miso_o !== 1'b0) begin errors++; $display("FAIL %s_miso: got %b want 0", tag, bus.miso_o); end
    checks++;
    if (bus.miso_oe_o !== 1'b0) begin errors++; $display("FAIL %s_miso_oe: got %b want 0", tag, bus.miso_oe_o); end
    checks++;
    if (bus.rx_data_o !== 8'h00) begin errors++; $display("FAIL %s_rx_data: got %h want 00", tag, bus.rx_data_o); end
    checks++;
    if (bus.rx_valid_o !== 1'b0) begin errors++; $display("FAIL %s_rx_valid: got %b want 0", tag, bus.rx_valid_o); end
    checks++;
    if (bus.tx_underrun_o !== 1'b0) begin errors++; $display("FAIL %s_underrun: got %b want 0", tag, bus.tx_underrun_o); end
    checks++;
    if (bus.frame_abort_o !== 1'b0) begin errors++; $display("FAIL %s_abort: got %b want 0", tag, bus.frame_abort_o); end
  endtask

  task automatic test_reset();
    reset_r = 1'b1;
    tick(3);
    reset_r = 1'b0;
    tick(1);
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    int r0, u0, a0;
    logic [N-1:0] mi;
    r0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt;
    write_tx(8'hA5);
    checks++;
    if (bus.tx_ready_o !== 1'b0) begin errors++; $display("FAIL basic_hold_full: tx_ready=%b want 0", bus.tx_ready_o); end
    frame_start();
    checks++;
    if (bus.miso_oe_o !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b want 1", bus.miso_oe_o); end
    checks++;
    if (bus.tx_ready_o !== 1'b1) begin errors++; $display("FAIL basic_hold_emptied: tx_ready=%b want 1", bus.tx_ready_o); end
    spi_bits(8'h3C, 8, 1'b1, mi);
    tick(8);
    checks++;
    if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso_word: got %h want a5", mi); end
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL basic_rx_pulses: got %0d want 1", rx_cnt - r0); end
    checks++;
    if (rx_log[r0[4:0]] !== 8'h3C) begin errors++; $display("FAIL basic_rx_word: got %h want 3c", rx_log[r0[4:0]]); end
    checks++;
    if (bus.rx_data_o !== 8'h3C) begin errors++; $display("FAIL basic_rx_hold: got %h want 3c", bus.rx_data_o); end
    checks++;
    if (und_cnt - u0 !== 0) begin errors++; $display("FAIL basic_underrun: got %0d want 0", und_cnt - u0); end
    checks++;
    if (abt_cnt - a0 !== 0) begin errors++; $display("FAIL basic_abort: got %0d want 0", abt_cnt - a0); end
    checks++;
    if (bus.miso_oe_o !== 1'b0 || bus.miso_o !== 1'b0) begin
      errors++; $display("FAIL basic_idle_pins: oe=%b miso=%b want 0 0", bus.miso_oe_o, bus.miso_o);
    end
  endtask

  task automatic test_back_to_back();
    int r0, u0;
    logic [N-1:0] m0, m1;
    r0 = rx_cnt; u0 = und_cnt;
    write_tx(8'h11);
    frame_start();
    write_tx(8'h22);
    spi_bits(8'hF0, 8, 1'b0, m0);
    spi_bits(8'h0F, 8, 1'b1, m1);
    tick(8);
    checks++;
    if (m0 !== 8'h11) begin errors++; $display("FAIL b2b_miso0: got %h want 11", m0); end
    checks++;
    if (m1 !== 8'h22) begin errors++; $display("FAIL b2b_miso1: got %h want 22", m1); end
    checks++;
    if (rx_cnt - r0 !== 2) begin errors++; $display("FAIL b2b_rx_pulses: got %0d want 2", rx_cnt - r0); end
    checks++;
    if (rx_log[r0[4:0]] !== 8'hF0) begin errors++; $display("FAIL b2b_rx0: got %h want f0", rx_log[r0[4:0]]); end
    checks++;
    if (rx_log[5'(r0 + 1)] !== 8'h0F) begin errors++; $display("FAIL b2b_rx1: got %h want 0f", rx_log[5'(r0 + 1)]); end
    checks++;
    if (und_cnt - u0 !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d want 0", und_cnt - u0); end
  endtask

  task automatic test_underrun();
    int r0, u0;
    logic [N-1:0] mi;
    r0 = rx_cnt; u0 = und_cnt;
    frame_start();
    spi_bits(8'h5A, 8, 1'b1, mi);
    tick(8);
    checks++;
    if (mi !== 8'h00) begin errors++; $display("FAIL underrun_miso: got %h want 00", mi); end
    checks++;
    if (und_cnt - u0 !== 1) begin errors++; $display("FAIL underrun_pulses: got %0d want 1", und_cnt - u0); end
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL underrun_rx_pulses: got %0d want 1", rx_cnt - r0); end
    checks++;
    if (bus.rx_data_o !== 8'h5A) begin errors++; $display("FAIL underrun_rx_word: got %h want 5a", bus.rx_data_o); end
  endtask

  task automatic test_abort();
    int r0, a0;
    logic [N-1:0] mi;
    r0 = rx_cnt; a0 = abt_cnt;
    frame_start();
    spi_bits(8'hFF, 5, 1'b1, mi);
    tick(8);
    checks++;
    if (abt_cnt - a0 !== 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", abt_cnt - a0); end
    checks++;
    if (rx_cnt - r0 !== 0) begin errors++; $display("FAIL abort_rx_pulses: got %0d want 0", rx_cnt - r0); end
    checks++;
    if (bus.rx_data_o !== 8'h5A) begin errors++; $display("FAIL abort_rx_kept: got %h want 5a", bus.rx_data_o); end
    write_tx(8'h96);
    frame_start();
    spi_bits(8'h69, 8, 1'b1, mi);
    tick(8);
    checks++;
    if (mi !== 8'h96) begin errors++; $display("FAIL abort_next_miso: got %h want 96", mi); end
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL abort_next_rx_pulses: got %0d want 1", rx_cnt - r0); end
    checks++;
    if (bus.rx_data_o !== 8'h69) begin errors++; $display("FAIL abort_next_rx: got %h want 69", bus.rx_data_o); end
    checks++;
    if (abt_cnt - a0 !== 1) begin errors++; $display("FAIL abort_next_no_abort: got %0d want 1", abt_cnt - a0); end
  endtask

  task automatic test_reset_mid_frame();
    int r0, a0;
    logic [N-1:0] mi;
    a0 = abt_cnt;
    write_tx(8'h77);
    frame_start();
    write_tx(8'h44);
    spi_bits(8'hFF, 3, 1'b0, mi);
    checks++;
    if (mi !== 8'h60) begin errors++; $display("FAIL rstmid_partial_miso: got %h want 60", mi); end
    reset_r    = 1'b1;
    bus.cs_n_i = 1'b1;
    tick(1);
    check_reset_outputs("rstmid");
    tick(2);
    reset_r = 1'b0;
    tick(6);
    checks++;
    if (abt_cnt - a0 !== 0) begin errors++; $display("FAIL rstmid_silent: aborts=%0d want 0", abt_cnt - a0); end
    r0 = rx_cnt;
    write_tx(8'h3C);
    frame_start();
    spi_bits(8'h81, 8, 1'b1, mi);
    tick(8);
    checks++;
    if (mi !== 8'h3C) begin errors++; $display("FAIL rstmid_next_miso: got %h want 3c", mi); end
    checks++;
    if (rx_cnt - r0 !== 1) begin errors++; $display("FAIL rstmid_next_rx_pulses: got %0d want 1", rx_cnt - r0); end
    checks++;
    if (bus.rx_data_o !== 8'h81) begin errors++; $display("FAIL rstmid_next_rx: got %h want 81", bus.rx_data_o); end
  endtask

  task automatic test_reload_write();
    int r0, u0, c0;
    logic [N-1:0] m0, m1, m2;
    r0 = rx_cnt; u0 = und_cnt;
    write_tx(8'h5C);
    frame_start();
    write_tx(8'hB7);
    c0 = acc_cnt;
    spi_bits(8'h12, 8, 1'b0, m0);
    // Two cycles after the last fall is driven, the fall is being detected and the reload is underway.
    tick(2);
    checks++;
    if (bus.tx_ready_o !== 1'b0) begin errors++; $display("FAIL reload_ready_low: got %b want 0", bus.tx_ready_o); end
    bus.tx_data_i  = 8'hE1;
    bus.tx_valid_i = 1'b1;
    tick(1);
    checks++;
    if (bus.tx_ready_o !== 1'b1) begin errors++; $display("FAIL reload_ready_next: got %b want 1", bus.tx_ready_o); end
    tick(1);
    bus.tx_valid_i = 1'b0;
    checks++;
    if (acc_cnt - c0 !== 1) begin errors++; $display("FAIL reload_accepts: got %0d want 1", acc_cnt - c0); end
    spi_bits(8'h34, 8, 1'b0, m1);
    spi_bits(8'h56, 8, 1'b1, m2);
    tick(8);
    checks++;
    if (m0 !== 8'h5C) begin errors++; $display("FAIL reload_miso0: got %h want 5c", m0); end
    checks++;
    if (m1 !== 8'hB7) begin errors++; $display("FAIL reload_miso1: got %h want b7", m1); end
    checks++;
    if (m2 !== 8'hE1) begin errors++; $display("FAIL reload_miso2: got %h want e1", m2); end
    checks++;
    if (rx_cnt - r0 !== 3) begin errors++; $display("FAIL reload_rx_pulses: got %0d want 3", rx_cnt - r0); end
    checks++;
    if (rx_log[5'(r0 + 2)] !== 8'h56) begin errors++; $display("FAIL reload_rx2: got %h want 56", rx_log[5'(r0 + 2)]); end
    checks++;
    if (und_cnt - u0 !== 0) begin errors++; $display("FAIL reload_underrun: got %0d want 0", und_cnt - u0); end
  endtask

  initial begin
    bus.sclk_i     = 1'b0;
    bus.cs_n_i     = 1'b1;
    bus.mosi_i     = 1'b0;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_reload_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: N, 8, data word width in bits (N >= 2).
REQ-002 clk_c  input  1  system clock, single clock domain.
REQ-003 reset_r  input  1  reset, synchronous to clk_c and active-high.
REQ-004 sclk_i  input  1  SPI serial clock from master, asynchronous to clk_c.
REQ-005 cs_n_i  input  1  SPI chip select from master, active-low, asynchronous.
REQ-006 mosi_i  input  1  serial data from master, asynchronous.
REQ-007 miso_o  output  1  serial data to master, MSB first.
REQ-008 miso_oe_o  output  1  miso output enable, high while the frame is selected.
REQ-009 tx_data_i  input  N  next word to transmit.
REQ-010 tx_valid_i  input  1  tx_data_i valid.
REQ-011 tx_ready_o  output  1  transmit holding register empty.
REQ-012 rx_data_o  output  N  last complete received word, held until the next word completes.
REQ-013 rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
REQ-014 tx_underrun_o  output  1  one-cycle pulse when a word is loaded with no valid tx data.
REQ-015 frame_abort_o  output  1  one-cycle pulse when cs_n rises with a partial word.

Function
REQ-016 SPI mode 0 (CPOL=0, CPHA=0): mosi sampled on sclk rising edge, miso changed on sclk falling edge.
REQ-017 sclk_i, cs_n_i and mosi_i each pass through a 2-flop synchronizer; edges are detected against a third registered copy; sclk frequency SHALL be <= clk_c/8.
REQ-018 Transmit holding register: one entry; tx_ready_o = empty; loaded when tx_valid_i && tx_ready_o; emptied when copied into the shift register.
REQ-019 FSM states: IDLE (cs high), LOAD (one cycle), SHIFT.
- IDLE -> LOAD on the detected cs_n falling edge.
- LOAD -> SHIFT unconditionally.
- Any state -> IDLE on the detected cs_n rising edge.
REQ-020 LOAD copies the holding register into the tx shift register; miso_o = bit N-1 from the cycle after LOAD.
REQ-021 If the holding register is empty at load, the shift register is loaded with all zeros and tx_underrun_o pulses.
REQ-022 SHIFT, detected sclk rise: the synchronized mosi bit shifts into the LSB of the rx shift register, and the bit counter increments.
REQ-023 Bit counter: width clog2(N); counts 0..N-1; last flag when count = N-1; wraps to 0 on the Nth rise.
REQ-024 On the Nth rise: the full word goes to rx_data_o, and rx_valid_o pulses exactly one clk_c cycle after the edge-detect cycle.
REQ-025 SHIFT, detected sclk fall:
- tx shift register shifts left (miso shows the next bit), except the fall following the Nth rise.
- On that fall the tx shift register reloads from the holding register (rules of REQ-020/021 apply), giving back-to-back words.
REQ-026 Simultaneous tx_valid_i write and reload in the same cycle: the reload takes the existing entry and the write is refused (tx_ready_o low that cycle).
REQ-027 cs_n rise with counter != 0: partial word discarded, rx_data_o unchanged, no rx_valid_o, frame_abort_o pulses, counter cleared. The loaded tx word is lost; the holding register is untouched.
REQ-028 cs_n rise with counter = 0: return to IDLE, no pulses.
REQ-029 miso_oe_o = 1 in LOAD and SHIFT, 0 in IDLE; miso_o = 0 whenever miso_oe_o = 0.

Reset
REQ-030 When reset_r is high on a clk_c edge:
- state = IDLE; counter = 0; all shift registers and the holding register are cleared.
- rx_data_o = 0; rx_valid_o, tx_underrun_o and frame_abort_o = 0.
- tx_ready_o = 1; miso_o = 0; miso_oe_o = 0.
- Synchronizer flops are set to the idle levels: sclk 0, cs_n 1.
REQ-031 Reset mid-frame aborts silently (no frame_abort_o); the block waits for the next cs_n falling edge.

Structure
REQ-032 Package spi_pkg holds the state enum (IDLE/LOAD/SHIFT) and the default word-width constant.
REQ-033 The bit counter is the sub-module spi_slave_bit_counter: clear, enable and last-flag, with the synchronous reset.

Verification
REQ-034 tx 0xA5 preloaded, master sends 0x3C in mode 0 at clk_c/8 -> master receives 0xA5; rx_data_o = 0x3C with a single rx_valid_o pulse.
REQ-035 Two back-to-back words without cs_n release; tx 0x11 then 0x22, mosi 0xF0 then 0x0F -> miso 0x11, 0x22; two rx_valid_o pulses carrying 0xF0 and 0x0F.
REQ-036 Nothing written to tx, master clocks 8 bits -> miso all zeros; tx_underrun_o pulses once; rx word still captured.
REQ-037 cs_n raised after 5 bits -> frame_abort_o pulses; rx_data_o keeps its prior value; the next full frame receives correctly.
REQ-038 reset_r asserted at bit 3 -> all outputs match REQ-030 on the next edge; a subsequent frame 0x81 is received correctly.
REQ-039 Write attempted in the reload cycle -> tx_ready_o low that cycle; the word is accepted in the next cycle; no data is lost or duplicated.
